decred_result_collector: RTL

//  Downstream consumer of the decred_hash_macro read port. Watches DATA_AVAILABLE of all hash

---
 rtl/decred_result_collector_if.sv | 34 +++
 rtl/decred_result_collector.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/decred_result_collector_if.sv
// Read-port and result-queue signals between the result collector, the hash macros
// and the controller.
interface decred_result_collector_if #(
    parameter int NUM_MACROS = 1,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  ENABLE;
    logic [NUM_MACROS-1:0] DATA_AVAILABLE;
    logic [NUM_MACROS-1:0] MACRO_RD_SELECT;
    logic [5:0]            HASH_ADDR;
    logic [7:0]            DATA_FROM_HASH;
    logic                  RESULT_VALID;
    logic [31:0]           RESULT_NONCE;
    logic [3:0]            RESULT_MACRO;
    logic                  RESULT_POP;
    logic [CW-1:0]         FIFO_COUNT;
    logic                  OVERFLOW;
    logic                  BUSY;
    logic                  IRQ;

    modport master (
        input  ENABLE, DATA_AVAILABLE, DATA_FROM_HASH, RESULT_POP,
        output MACRO_RD_SELECT, HASH_ADDR, RESULT_VALID, RESULT_NONCE, RESULT_MACRO,
               FIFO_COUNT, OVERFLOW, BUSY, IRQ
    );

    modport slave (
        output ENABLE, DATA_AVAILABLE, DATA_FROM_HASH, RESULT_POP,
        input  MACRO_RD_SELECT, HASH_ADDR, RESULT_VALID, RESULT_NONCE, RESULT_MACRO,
               FIFO_COUNT, OVERFLOW, BUSY, IRQ
    );
endinterface

// File: rtl/decred_result_collector.sv
// Round-robin collector of hash-macro results: latches DATA_AVAILABLE edges, reads the
// 4-byte nonce over the shared read port and queues {macro id, nonce} in a small FIFO.
module decred_result_collector #(
    parameter int         NUM_MACROS = 1,
    parameter logic [5:0] NONCE_ADDR = 6'h3C,
    parameter int         FIFO_DEPTH = 4
) (
    input logic                       CLK,
    input logic                       RESET_N,
    decred_result_collector_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, READ} state_t;
    typedef struct packed {
        logic [3:0]  mac_id;
        logic [31:0] nonce;
    } entry_t;

    state_t                state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [3:0]            sel, sel_nxt;
    logic [3:0]            rr_ptr, rr_ptr_nxt;
    logic [NUM_MACROS-1:0] prev_avail, pending, rise, grant_mask, rd_select;
    logic                  overflow;
    logic [3:0]            grant_idx, hi_idx, lo_idx;
    logic                  grant_found, hi_found, grant, push, pop, bus_active;
    logic [23:0]           nonce_lo;
    entry_t                mem [FIFO_DEPTH];
    entry_t                head;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    assign rise = bus.DATA_AVAILABLE & ~prev_avail;

    // Descending scan leaves the lowest pending index at/after rr_ptr in hi_idx and the
    // lowest pending index overall in lo_idx (the wrap-around choice).
    always_comb begin
        hi_idx      = '0;
        lo_idx      = '0;
        hi_found    = 1'b0;
        grant_found = 1'b0;
        for (int i = NUM_MACROS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx      = 4'(i);
                grant_found = 1'b1;
                if (4'(i) >= rr_ptr) begin
                    hi_idx   = 4'(i);
                    hi_found = 1'b1;
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        grant      = 1'b0;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ENABLE && grant_found && (count < CW'(FIFO_DEPTH))) begin
                    grant      = 1'b1;
                    state_nxt  = READ;
                    cnt_nxt    = 3'd0;
                    sel_nxt    = grant_idx;
                    rr_ptr_nxt = (int'(grant_idx) == NUM_MACROS - 1) ? 4'd0 : grant_idx + 4'd1;
                end
            end
            READ: begin
                if (cnt == 3'd4) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_MACROS; i++) begin
            grant_mask[i] = grant && (grant_idx == 4'(i));
            rd_select[i]  = bus_active && (sel == 4'(i));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            rr_ptr     <= '0;
            prev_avail <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            rr_ptr     <= rr_ptr_nxt;
            prev_avail <= bus.DATA_AVAILABLE;
            // A new edge on a granted bit re-arms it in the same cycle.
            pending    <= (pending & ~grant_mask) | rise;
            if (|(rise & pending)) overflow <= 1'b1;
        end
    end

    // Read data lags the address by one cycle, so byte k lands at cnt k+1; the shift
    // register leaves bytes 0..2 in little-endian order after cnt 3.
    always_ff @(posedge CLK) begin
        if (state == READ && cnt != 3'd0 && cnt != 3'd4)
            nonce_lo <= {bus.DATA_FROM_HASH, nonce_lo[23:8]};
        if (push)
            mem[wr_ptr] <= '{mac_id: sel, nonce: {bus.DATA_FROM_HASH, nonce_lo}};
    end

    assign pop = bus.RESULT_POP && (count != '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign bus_active          = (state == READ) && (cnt != 3'd4);
    assign head                = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.MACRO_RD_SELECT = rd_select;
    assign bus.HASH_ADDR       = bus_active ? NONCE_ADDR + {3'b000, cnt} : 6'd0;
    assign bus.BUSY            = (state == READ);
    assign bus.RESULT_VALID    = (count != '0);
    assign bus.IRQ             = (count != '0);
    assign bus.RESULT_NONCE    = head.nonce;
    assign bus.RESULT_MACRO    = head.mac_id;
    assign bus.FIFO_COUNT      = count;
    assign bus.OVERFLOW        = overflow;
endmodule
